// File: rtl/parking_lane_arbiter.sv
// parking_lane_arbiter: shares one parking gate controller among LANES lanes
// (exits before entries, round-robin within each class). Rev 1.0
`default_nettype none

module parking_lane_arbiter #(
  parameter int LANES       = 4,
  parameter int PASS_W      = 8,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        lane_enter,
  input  logic [LANES-1:0]        lane_exit,
  input  logic [LANES*PASS_W-1:0] lane_passcode,
  output logic                    ctl_enter_req,
  output logic                    ctl_exit_req,
  output logic [PASS_W-1:0]       ctl_passcode,
  input  logic                    ctl_entry_gate_open,
  input  logic                    ctl_exit_gate_open,
  output logic [LANES-1:0]        lane_done,
  output logic [LANES-1:0]        lane_ok,
  output logic                    busy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0]        state;
  logic [LANES-1:0]  enter_pend;
  logic [LANES-1:0]  exit_pend;
  logic [PASS_W-1:0] pass_store [LANES];
  logic [LW-1:0]     ptr;
  logic [LW-1:0]     gnt_lane;
  logic              gnt_exit;
  logic              opened;
  logic [2:0]        wait_cnt;

  logic              any_exit;
  logic              any_enter;
  logic [LANES-1:0]  req_vec;
  logic              found;
  logic [LW-1:0]     sel;
  logic [LW-1:0]     cand;
  int                idx;
  logic              grant;
  logic [LANES-1:0]  sel_onehot;
  logic [LANES-1:0]  gnt_onehot;
  logic [LANES-1:0]  clr_enter;
  logic [LANES-1:0]  clr_exit;
  logic              gate_match;

  // Round-robin search starts one past the last granted lane.
  always_comb begin
    any_exit  = |exit_pend;
    any_enter = |enter_pend;
    req_vec   = any_exit ? exit_pend : enter_pend;
    found     = 1'b0;
    sel       = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 1; k <= LANES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= LANES) idx = idx - LANES;
      cand = LW'(idx);
      if (!found && req_vec[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign grant      = (state == S_IDLE) && (any_exit || any_enter);
  assign sel_onehot = LANES'(1) << sel;
  assign gnt_onehot = LANES'(1) << gnt_lane;
  assign clr_exit   = (grant && any_exit)  ? sel_onehot : '0;
  assign clr_enter  = (grant && !any_exit) ? sel_onehot : '0;
  assign gate_match = gnt_exit ? ctl_exit_gate_open : ctl_entry_gate_open;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      enter_pend    <= '0;
      exit_pend     <= '0;
      ptr           <= LW'(LANES - 1);
      gnt_lane      <= '0;
      gnt_exit      <= 1'b0;
      opened        <= 1'b0;
      wait_cnt      <= '0;
      ctl_enter_req <= 1'b0;
      ctl_exit_req  <= 1'b0;
      ctl_passcode  <= '0;
      lane_done     <= '0;
      lane_ok       <= '0;
      busy          <= 1'b0;
      for (int i = 0; i < LANES; i++) pass_store[i] <= '0;
    end else begin
      // A pulse landing on the grant edge re-queues: the set wins over the clear.
      enter_pend <= (enter_pend & ~clr_enter) | lane_enter;
      exit_pend  <= (exit_pend  & ~clr_exit)  | lane_exit;
      for (int i = 0; i < LANES; i++) begin
        if (lane_enter[i] && (!enter_pend[i] || clr_enter[i]))
          pass_store[i] <= lane_passcode[i*PASS_W +: PASS_W];
      end
      lane_done <= '0;
      lane_ok   <= '0;

      case (state)
        S_IDLE: begin
          if (grant) begin
            ptr           <= sel;
            gnt_lane      <= sel;
            gnt_exit      <= any_exit;
            ctl_enter_req <= !any_exit;
            ctl_exit_req  <= any_exit;
            ctl_passcode  <= any_exit ? '0 : pass_store[sel];
            busy          <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ctl_enter_req <= 1'b0;
          ctl_exit_req  <= 1'b0;
          opened        <= 1'b0;
          wait_cnt      <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          opened   <= opened | gate_match;
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_cnt == WAIT_LAST) begin
            lane_done <= gnt_onehot;
            lane_ok   <= (opened | gate_match) ? gnt_onehot : '0;
            state     <= S_REPORT;
          end
        end
        S_REPORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parking_lane_arbiter.sv
// tb_parking_lane_arbiter: scoreboard bench with a small gate-controller model.
// Rev 1.0
`default_nettype none

module tb_parking_lane_arbiter;

  localparam int LANES  = 4;
  localparam int PASS_W = 8;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [LANES-1:0]        lane_enter = '0;
  logic [LANES-1:0]        lane_exit = '0;
  logic [LANES*PASS_W-1:0] lane_passcode = '0;
  logic                    ctl_enter_req;
  logic                    ctl_exit_req;
  logic [PASS_W-1:0]       ctl_passcode;
  logic                    ctl_entry_gate_open;
  logic                    ctl_exit_gate_open;
  logic [LANES-1:0]        lane_done;
  logic [LANES-1:0]        lane_ok;
  logic                    busy;

  parking_lane_arbiter #(.LANES(LANES), .PASS_W(PASS_W), .WAIT_CYCLES(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .lane_enter          (lane_enter),
    .lane_exit           (lane_exit),
    .lane_passcode       (lane_passcode),
    .ctl_enter_req       (ctl_enter_req),
    .ctl_exit_req        (ctl_exit_req),
    .ctl_passcode        (ctl_passcode),
    .ctl_entry_gate_open (ctl_entry_gate_open),
    .ctl_exit_gate_open  (ctl_exit_gate_open),
    .lane_done           (lane_done),
    .lane_ok             (lane_ok),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: gate opens two cycles after the request when allowed.
  logic [1:0] e_pipe = '0;
  logic [1:0] x_pipe = '0;
  int car_count = 0;
  localparam int CAPACITY = 20;
  always @(posedge clk) begin
    e_pipe <= {e_pipe[0], ctl_enter_req && (ctl_passcode == 8'hFF) && (car_count < CAPACITY)};
    x_pipe <= {x_pipe[0], ctl_exit_req && (car_count > 0)};
    if (e_pipe[1]) car_count <= car_count + 1;
    else if (x_pipe[1]) car_count <= car_count - 1;
  end
  assign ctl_entry_gate_open = e_pipe[1];
  assign ctl_exit_gate_open  = x_pipe[1];

  typedef struct packed {
    logic       is_exit;
    logic [7:0] pass;
  } iss_t;

  iss_t       iss_q[$];
  logic [7:0] done_q[$];   // {done, ok}
  int checks = 0;
  int errors = 0;
  int last_issue = -1;

  function automatic iss_t mk_iss(input logic is_exit, input logic [7:0] pass);
    iss_t r;
    r.is_exit = is_exit;
    r.pass    = pass;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues or reports.
  iss_t       mon_e;
  logic [7:0] mon_d;
  always @(negedge clk) begin
    if (!reset) begin
      if (ctl_enter_req || ctl_exit_req) begin
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got enter=%0b exit=%0b passcode=%h, required no request",
                   ctl_enter_req, ctl_exit_req, ctl_passcode);
        end else begin
          mon_e = iss_q.pop_front();
          check("issue_type", {30'd0, ctl_exit_req, ctl_enter_req}, {30'd0, mon_e.is_exit, !mon_e.is_exit});
          check("issue_passcode", {24'd0, ctl_passcode}, {24'd0, mon_e.pass});
        end
        if (last_issue >= 0) check("issue_gap_ge6", {31'd0, (cyc - last_issue) >= 6}, 32'd1);
        last_issue = cyc;
      end
      if (lane_done != '0) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done=%b ok=%b, required no done", lane_done, lane_ok);
        end else begin
          mon_d = done_q.pop_front();
          check("done_vector", {28'd0, lane_done}, {28'd0, mon_d[7:4]});
          check("ok_vector", {28'd0, lane_ok}, {28'd0, mon_d[3:0]});
          check("done_latency", cyc - last_issue, 32'd4);
        end
      end
    end
  end

  task automatic pulse(input logic [3:0] en, input logic [3:0] ex, input logic [31:0] pc);
    @(negedge clk);
    lane_enter    = en;
    lane_exit     = ex;
    lane_passcode = pc;
    @(negedge clk);
    lane_enter = '0;
    lane_exit  = '0;
  endtask

  task automatic wait_done(input int lane, input string name);
    int n = 0;
    while (!lane_done[lane] && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, lane_done[lane]}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_prev;
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_enter_req", {31'd0, ctl_enter_req}, 32'd0);
    check("rst_exit_req", {31'd0, ctl_exit_req}, 32'd0);
    check("rst_passcode", {24'd0, ctl_passcode}, 32'd0);
    check("rst_done", {28'd0, lane_done}, 32'd0);
    check("rst_ok", {28'd0, lane_ok}, 32'd0);
    reset = 1'b0;

    // Single entry on lane 2, valid passcode
    iss_q.push_back(mk_iss(1'b0, 8'hFF));
    done_q.push_back(8'b0100_0100);
    pulse(4'b0100, 4'b0000, 32'h00FF_0000);
    wait_done(2, "t1_done_seen");

    // Denied entry on lane 1
    iss_q.push_back(mk_iss(1'b0, 8'h3C));
    done_q.push_back(8'b0010_0000);
    pulse(4'b0010, 4'b0000, 32'h0000_3C00);
    wait_done(1, "t2_done_seen");
    check("t2_busy_in_report", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t2_busy_after_report", {31'd0, busy}, 32'd0);

    // Exit priority: lane 3 exit beats lane 0 entry
    iss_q.push_back(mk_iss(1'b1, 8'h00));
    iss_q.push_back(mk_iss(1'b0, 8'hFF));
    done_q.push_back(8'b1000_1000);
    done_q.push_back(8'b0001_0001);
    pulse(4'b0001, 4'b1000, 32'h0000_00FF);
    wait_done(3, "t3_exit_done_seen");
    wait_done(0, "t3_entry_done_seen");

    // Overrun ignored, then requeue on the grant edge
    iss_q.push_back(mk_iss(1'b0, 8'hFF));
    iss_q.push_back(mk_iss(1'b0, 8'hFF));
    iss_q.push_back(mk_iss(1'b0, 8'hFF));
    done_q.push_back(8'b0001_0001);
    done_q.push_back(8'b0010_0010);
    done_q.push_back(8'b0010_0010);
    pulse(4'b0001, 4'b0000, 32'h0000_00FF);
    pulse(4'b0010, 4'b0000, 32'h0000_FF00);
    pulse(4'b0010, 4'b0000, 32'h0000_0000);
    wait_done(0, "t5_lane0_done_seen");
    @(negedge clk);
    lane_enter    = 4'b0010;
    lane_passcode = 32'h0000_FF00;
    @(negedge clk);
    lane_enter = '0;
    wait_done(1, "t5_lane1_done_seen");
    @(negedge clk);
    wait_done(1, "t5_requeue_done_seen");

    // Reset during WAIT with two lanes still pending
    iss_q.push_back(mk_iss(1'b0, 8'hFF));
    pulse(4'b1101, 4'b0000, 32'hFFFF_00FF);
    n = 0;
    while (!ctl_enter_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_issue_seen", {31'd0, ctl_enter_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_busy_after_reset", {31'd0, busy}, 32'd0);
    check("t6_enter_req_after_reset", {31'd0, ctl_enter_req}, 32'd0);
    check("t6_exit_req_after_reset", {31'd0, ctl_exit_req}, 32'd0);
    check("t6_passcode_after_reset", {24'd0, ctl_passcode}, 32'd0);
    check("t6_done_after_reset", {28'd0, lane_done}, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_no_stale_request", {31'd0, busy}, 32'd0);

    // Round-robin from reset pointer: order 0,1,2,3, six cycles apart
    for (int i = 0; i < 4; i++) iss_q.push_back(mk_iss(1'b0, 8'hFF));
    done_q.push_back(8'b0001_0001);
    done_q.push_back(8'b0010_0010);
    done_q.push_back(8'b0100_0100);
    done_q.push_back(8'b1000_1000);
    pulse(4'b1111, 4'b0000, 32'hFFFF_FFFF);
    wait_done(0, "t4_lane0_done_seen");
    t_prev = cyc;
    for (int l = 1; l < 4; l++) begin
      wait_done(l, "t4_done_seen");
      check("t4_done_spacing", cyc - t_prev, 32'd6);
      t_prev = cyc;
    end

    n = 0;
    while ((iss_q.size() + done_q.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", iss_q.size() + done_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
